// File: rtl/uart_pkg.sv
// Shared types, oversampling constants and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        BRKWAIT = 3'd5
    } rx_state_t;

    typedef enum logic [1:0] {
        WLS5 = 2'b00,
        WLS6 = 2'b01,
        WLS7 = 2'b10,
        WLS8 = 2'b11
    } wls_t;

    localparam logic [4:0] OS16  = 5'd16;
    localparam logic [4:0] OS13  = 5'd13;
    localparam logic [4:0] MID16 = 5'd8;
    localparam logic [4:0] MID13 = 5'd6;

    function automatic logic [3:0] wls_to_bits(input wls_t wls);
        logic [3:0] bits;
        case (wls)
            WLS5:    bits = 4'd5;
            WLS6:    bits = 4'd6;
            WLS7:    bits = 4'd7;
            WLS8:    bits = 4'd8;
            default: bits = 4'd8;
        endcase
        return bits;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the serial input plus falling-edge detect.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic sin,
    output logic sin_s,
    output logic sin_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain and previous-value flop, preset to the idle-high line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {SYNC_STAGES{1'b1}};
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sin_s    = sync_q[SYNC_STAGES-1];
    assign sin_fall = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, mid-bit sampling, 5-8 data bits, optional parity, stop/break check.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote around each bit centre, decided one tick late.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       bclk,
    input  logic       mode_osl,
    input  logic       sin,
    input  logic [1:0] lcr_wls,
    input  logic       lcr_pen,
    input  logic       lcr_eps,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_pe,
    output logic       rx_fe,
    output logic       rx_bi,
    output logic       rx_busy
);

    logic       sin_s;
    logic       sin_fall;

    rx_state_t  state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       zero_q, zero_d;
    logic       osl_q, osl_d;
    logic [3:0] nbits_q, nbits_d;
    logic       pen_q, pen_d;
    logic       eps_q, eps_d;

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       bi_q, bi_d;
    logic       busy_q, busy_d;

    logic [4:0] os_s, mid_s, start_tap_s, tap_s, next_cnt_s;
    logic       at_tap_s, bit_s, last_bit_s, brk_s, done_s;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .sin      (sin),
        .sin_s    (sin_s),
        .sin_fall (sin_fall)
    );

    assign os_s  = osl_q ? OS13 : OS16;
    assign mid_s = osl_q ? MID13 : MID16;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] smp_q;

    // Last two oversamples feeding the vote; the current one completes the triple.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            smp_q <= 2'b11;
        end else if (bclk && (state_q != IDLE)) begin
            smp_q <= {smp_q[0], sin_s};
        end else begin
            smp_q <= smp_q;
        end
    end

    assign start_tap_s = mid_s;
    assign bit_s       = maj3(smp_q[1], smp_q[0], sin_s);
`else
    assign start_tap_s = mid_s - 5'd1;
    assign bit_s       = sin_s;
`endif

    assign tap_s      = (state_q == START) ? start_tap_s : (os_s - 5'd1);
    assign at_tap_s   = bclk && (cnt_q == tap_s);
    assign next_cnt_s = !bclk ? cnt_q : (at_tap_s ? 5'd0 : cnt_q + 5'd1);
    assign last_bit_s = ({1'b0, bit_idx_q} == (nbits_q - 4'd1));
    assign brk_s      = zero_q && !bit_s;
    assign done_s     = (state_q == STOP) && at_tap_s;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sin_fall) state_d = START; else state_d = IDLE;
            START:   if (at_tap_s) state_d = bit_s ? IDLE : DATA; else state_d = START;
            DATA:    if (at_tap_s && last_bit_s) state_d = pen_q ? PARITY : STOP; else state_d = DATA;
            PARITY:  if (at_tap_s) state_d = STOP; else state_d = PARITY;
            STOP:    if (at_tap_s) state_d = brk_s ? BRKWAIT : IDLE; else state_d = STOP;
            BRKWAIT: if (sin_s) state_d = IDLE; else state_d = BRKWAIT;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: tick counter, shifter, running parity and all-zero tracker.
    always_comb begin
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        zero_d    = zero_q;
        osl_d     = osl_q;
        nbits_d   = nbits_q;
        pen_d     = pen_q;
        eps_d     = eps_q;
        case (state_q)
            IDLE: begin
                if (sin_fall) begin
                    cnt_d     = 5'd0;
                    bit_idx_d = 3'd0;
                    shift_d   = 8'd0;
                    par_d     = 1'b0;
                    zero_d    = 1'b1;
                    osl_d     = mode_osl;
                    nbits_d   = wls_to_bits(wls_t'(lcr_wls));
                    pen_d     = lcr_pen;
                    eps_d     = lcr_eps;
                end else begin
                    cnt_d = 5'd0;
                end
            end
            START, STOP: cnt_d = next_cnt_s;
            DATA: begin
                cnt_d = next_cnt_s;
                if (at_tap_s) begin
                    shift_d[bit_idx_q] = bit_s;
                    par_d              = par_q ^ bit_s;
                    zero_d             = zero_q & ~bit_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                end else begin
                    shift_d = shift_q;
                end
            end
            PARITY: begin
                cnt_d = next_cnt_s;
                if (at_tap_s) begin
                    par_d  = par_q ^ bit_s;
                    zero_d = zero_q & ~bit_s;
                end else begin
                    par_d = par_q;
                end
            end
            default: cnt_d = 5'd0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= 5'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            zero_q    <= 1'b0;
            osl_q     <= 1'b0;
            nbits_q   <= 4'd8;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            zero_q    <= zero_d;
            osl_q     <= osl_d;
            nbits_q   <= nbits_d;
            pen_q     <= pen_d;
            eps_q     <= eps_d;
        end
    end

    // Output next values; par_q holds the ones-count parity of data plus parity bit at STOP.
    always_comb begin
        valid_d = 1'b0;
        data_d  = data_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        bi_d    = bi_q;
        busy_d  = (state_d != IDLE);
        if (done_s) begin
            valid_d = 1'b1;
            data_d  = brk_s ? 8'd0 : shift_q;
            pe_d    = pen_q && (eps_q ? par_q : !par_q);
            fe_d    = !bit_s;
            bi_d    = brk_s;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            bi_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            bi_q    <= bi_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_pe    = pe_q;
    assign rx_fe    = fe_q;
    assign rx_bi    = bi_q;
    assign rx_busy  = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model, expectation queue and per-cycle compare.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       bclk = 1'b0;
    logic       mode_osl = 1'b0;
    logic       sin = 1'b1;
    logic [1:0] lcr_wls = 2'b11;
    logic       lcr_pen = 1'b0;
    logic       lcr_eps = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_pe, rx_fe, rx_bi, rx_busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int div = 0;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
        int         t_edge;
        int         lat;
    } exp_t;

    exp_t expq[$];

    logic [7:0] last_data = 8'h00;
    logic       last_pe = 1'b0, last_fe = 1'b0, last_bi = 1'b0;

    uart_rx dut (
        .clk(clk), .rstn(rstn), .bclk(bclk), .mode_osl(mode_osl), .sin(sin),
        .lcr_wls(lcr_wls), .lcr_pen(lcr_pen), .lcr_eps(lcr_eps),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_pe(rx_pe), .rx_fe(rx_fe),
        .rx_bi(rx_bi), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        div  <= (div + 1) % 4;
        bclk <= (div == 2);
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Character and flags a frame must produce, from the line-level rules.
    function automatic exp_t model(input logic [7:0] d, input int nb, input logic pen,
                                   input logic eps, input logic pb, input logic stop);
        exp_t e;
        int ones = 0;
        logic [7:0] dm;
        dm = d & 8'((1 << nb) - 1);
        for (int i = 0; i < nb; i++) ones += int'(dm[i]);
        if (pen) ones += int'(pb);
        e.pe = pen && (eps ? (ones % 2 == 1) : (ones % 2 == 0));
        e.fe = !stop;
        e.bi = (dm == 8'h00) && !(pen && pb) && !stop;
        e.data = e.bi ? 8'h00 : dm;
        e.t_edge = 0;
        e.lat = 0;
        return e;
    endfunction

    function automatic int latency(input logic osl, input int nframe_bits);
        int k;
        k = (osl ? 6 : 8) + nframe_bits * (osl ? 13 : 16);
`ifdef UART_RX_MAJORITY_EN
        k = k + 1;
`endif
        return 4 * k;
    endfunction

    task automatic send_frame(input logic [7:0] d, input int nb, input logic osl, input logic pen,
                              input logic eps, input logic pb, input logic stop, input logic scramble);
        int bitclk;
        exp_t e;
        bitclk = osl ? 52 : 64;
        e = model(d, nb, pen, eps, pb, stop);
        mode_osl = osl;
        lcr_wls  = 2'(nb - 5);
        lcr_pen  = pen;
        lcr_eps  = eps;
        @(negedge clk);
        sin = 1'b0;
        e.t_edge = cyc;
        e.lat = latency(osl, nb + int'(pen) + 1);
        expq.push_back(e);
        repeat (bitclk) @(negedge clk);
        if (scramble) begin
            mode_osl = 1'($urandom_range(0, 1));
            lcr_wls  = 2'($urandom_range(0, 3));
            lcr_pen  = 1'($urandom_range(0, 1));
            lcr_eps  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < nb; i++) begin
            sin = d[i];
            repeat (bitclk) @(negedge clk);
        end
        if (pen) begin
            sin = pb;
            repeat (bitclk) @(negedge clk);
        end
        sin = stop;
        repeat (bitclk) @(negedge clk);
        sin = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (expq.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL missing_valid: %0d frames pending, expected 0", expq.size());
            expq.delete();
        end
    endtask

    // Every-cycle compare: pulses against the queue head, held values otherwise.
    always @(negedge clk) begin : cmp
        exp_t e;
        int dt;
        if (!rstn) begin
            chk("reset_outputs", {rx_data, rx_valid, rx_pe, rx_fe, rx_bi, rx_busy}, 32'h0);
            last_data <= 8'h00;
            last_pe <= 1'b0;
            last_fe <= 1'b0;
            last_bi <= 1'b0;
        end else if (rx_valid) begin
            n_chk++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: rx_valid=1 at cycle %0d, expected no character", cyc);
            end else begin
                e = expq.pop_front();
                chk("rx_data", rx_data, e.data);
                chk("rx_pe", rx_pe, e.pe);
                chk("rx_fe", rx_fe, e.fe);
                chk("rx_bi", rx_bi, e.bi);
                dt = cyc - e.t_edge;
                n_chk++;
                if (dt < e.lat - 1 || dt > e.lat + 4) begin
                    n_fail++;
                    $display("FAIL valid_timing: %0d cycles after start edge, expected %0d..%0d",
                             dt, e.lat - 1, e.lat + 4);
                end
                last_data <= e.data;
                last_pe <= e.pe;
                last_fe <= e.fe;
                last_bi <= e.bi;
            end
        end else begin
            chk("hold", {rx_data, rx_pe, rx_fe, rx_bi}, {last_data, last_pe, last_fe, last_bi});
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    initial begin : stim
        exp_t p;
        logic [7:0] d;
        int nb;
        logic osl, pen, eps, pb, stop;

        #1 rstn = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_state", {rx_data, rx_valid, rx_pe, rx_fe, rx_bi, rx_busy}, 32'h0);
        rstn = 1'b1;
        repeat (20) @(negedge clk);

        // Hand-computed expectations that pin the model.
        p = model(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pin_8n1", {p.data, p.pe, p.fe, p.bi}, {8'hA5, 3'b000});
        p = model(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("pin_7e1_bad", {p.data, p.pe, p.fe, p.bi}, {8'h35, 3'b100});
        p = model(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pin_fe", {p.data, p.pe, p.fe, p.bi}, {8'h5A, 3'b010});
        p = model(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pin_break", {p.data, p.pe, p.fe, p.bi}, {8'h00, 3'b011});
        p = model(8'h1F, 5, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pin_5o1", {p.data, p.pe, p.fe, p.bi}, {8'h1F, 3'b000});

        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain(200);
        repeat (64) @(negedge clk);

        send_frame(8'h35, 7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drain(200);
        repeat (64) @(negedge clk);

        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain(200);
        repeat (80) @(negedge clk);

        // Line held low for 12 bit times: one break character, then silence until high.
        p = model(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        mode_osl = 1'b0;
        lcr_wls = 2'b11;
        lcr_pen = 1'b0;
        @(negedge clk);
        sin = 1'b0;
        p.t_edge = cyc;
        p.lat = latency(1'b0, 9);
        expq.push_back(p);
        repeat (12 * 64) @(negedge clk);
        sin = 1'b1;
        drain(10);
        repeat (64) @(negedge clk);
        chk("busy_after_break", rx_busy, 1'b0);

        // Glitch of three ticks: false start, no character.
        @(negedge clk);
        sin = 1'b0;
        repeat (12) @(negedge clk);
        sin = 1'b1;
        repeat (8) @(negedge clk);
        chk("busy_in_glitch", rx_busy, 1'b1);
        repeat (64) @(negedge clk);
        chk("busy_after_glitch", rx_busy, 1'b0);

        // 13x, 5O1, two frames back to back.
        send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drain(200);
        repeat (64) @(negedge clk);

        // Reset during data bit 4 aborts the frame.
        mode_osl = 1'b0;
        lcr_wls = 2'b11;
        lcr_pen = 1'b0;
        d = 8'h96;
        @(negedge clk);
        sin = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sin = d[i];
            repeat (64) @(negedge clk);
        end
        sin = d[4];
        repeat (32) @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("reset_midframe", {rx_data, rx_valid, rx_pe, rx_fe, rx_bi, rx_busy}, 32'h0);
        sin = 1'b1;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (128) @(negedge clk);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain(200);
        repeat (64) @(negedge clk);

        // Randomized frames with config scrambled mid-frame.
        for (int f = 0; f < 40; f++) begin
            d    = 8'($urandom);
            nb   = 5 + int'($urandom_range(0, 3));
            osl  = ($urandom_range(0, 3) == 0);
            pen  = 1'($urandom_range(0, 1));
            eps  = 1'($urandom_range(0, 1));
            pb   = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 6) == 0) begin
                d  = 8'h00;
                pb = 1'b0;
            end
            send_frame(d, nb, osl, pen, eps, pb, stop, 1'b1);
            drain(200);
            if (!stop) begin
                repeat (64 + $urandom_range(0, 20)) @(negedge clk);
            end else if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
            end
        end
        repeat (64) @(negedge clk);
        chk("busy_final", rx_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receive stage that consumes the oversampling tick `bclk` from the baud generator and deserialises the asynchronous `sin` line into parallel characters. Start-bit edge detection and validation, mid-bit sampling, 5–8 data bits, optional even/odd parity, and stop-bit check. Presents each character with parity-error, framing-error and break flags to the downstream RX FIFO / register block.

Parameters:
SYNC_STAGES, 2, number of flops in the `sin` metastability synchroniser (minimum 2).

Ports:
clk       input   1  system clock
rstn      input   1  asynchronous active-low reset
bclk      input   1  oversample enable; one clk cycle high per oversample period
mode_osl  input   1  oversample select: 0 = 16x, 1 = 13x
sin       input   1  asynchronous serial input; idles high
lcr_wls   input   2  word length: 00=5, 01=6, 10=7, 11=8 bits
lcr_pen   input   1  parity enable
lcr_eps   input   1  1 = even parity, 0 = odd
rx_data   output  8  received character, LSB-aligned, unused upper bits 0
rx_valid  output  1  one-clk pulse: character and flags valid
rx_pe     output  1  parity error, qualified by rx_valid
rx_fe     output  1  framing error, qualified by rx_valid
rx_bi     output  1  break indication, qualified by rx_valid
rx_busy   output  1  high while not in IDLE

Behaviour:
- Clock and reset: single clock `clk`. Reset `rstn` is asynchronous and active-low.
- Reset: all outputs 0, FSM in IDLE, synchroniser flops preset to 1. Reset mid-frame aborts the frame with no `rx_valid`.
- Oversample constants: OS = 16 or 13; MID = 8 or 6. `mode_osl`, `lcr_wls`, `lcr_pen` and `lcr_eps` are latched at start detection. Changes mid-frame have no effect until the next frame.
- Edge detection: falling edge of synchronised `sin` (1→0), evaluated every clk, not gated by `bclk`.
- Tick counter: counts `bclk` pulses and clears on each sample.
- States:
  - IDLE: falling edge → START, cnt = 0.
  - START: sample at the tick where cnt == MID-1. If low → DATA, bit index = 0. If high → IDLE (false start, no `rx_valid`).
  - DATA: sample at the tick where cnt == OS-1. Bits are shifted in LSB first. After WLS bits → PARITY if pen, otherwise STOP.
  - PARITY: sample at cnt == OS-1. `pe` = 1 if the ones-count of data plus parity bit is odd when eps = 1, or even when eps = 0.
  - STOP: sample at cnt == OS-1. Low → `fe` = 1.
  - After the stop sample, register outputs and pulse `rx_valid` on the next clk. `rx_data`, `rx_pe`, `rx_fe` and `rx_bi` hold until the next `rx_valid`.
  - Then return to IDLE, or to BRKWAIT if break.
- Break: data bits, parity bit (if enabled) and stop bit all 0. Result: `rx_bi` = 1, `rx_fe` = 1, `rx_data` = 0. Then enter BRKWAIT.
  - BRKWAIT: wait for synchronised `sin` = 1, then IDLE. No further `rx_valid` during the line-low period.
- Back-to-back frames: the stop bit is sampled mid-bit, so a start edge arriving in the second half of the stop bit is detected in the cycle after the return to IDLE.
- Simultaneous events: `bclk` coincident with the start edge is not counted; counting begins on the following tick.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of samples at cnt == MID-2, MID-1 and MID (relative to the bit centre; start bit uses the same three ticks). Bit decision at the third sample.
- Undefined: single sample as specified above.
- Frame timing at bit boundaries is identical in both cases.

Decomposition:
- Package `uart_pkg`: `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BRKWAIT); constants OS16 = 16, OS13 = 13, MID16 = 8, MID13 = 6; `wls_t` encoding with a `wls_to_bits()` function.
- Sub-module `uart_rx_sync`: SYNC_STAGES synchroniser plus falling-edge detect; outputs `sin_s` and `sin_fall`.

Test Plan:
- Bench drives `bclk` every 4 clk, `mode_osl` = 0.
- 8N1, byte 0xA5 → one `rx_valid`, `rx_data` = 0xA5, pe/fe/bi = 0.
- 7E1, send 0x35 with parity bit 1 (wrong) → `rx_data` = 0x35, `rx_pe` = 1, `rx_fe` = 0.
- 8N1, 0x5A with stop bit forced low → `rx_fe` = 1, `rx_bi` = 0.
- `sin` held low for 12 bit times → one `rx_valid` with `rx_bi` = 1, `rx_fe` = 1, `rx_data` = 0x00. No second pulse until `sin` returns high.
- Glitch: `sin` low for 3 `bclk` ticks → no `rx_valid`, `rx_busy` back to 0.
- `mode_osl` = 1, 5O1, 0x1F back-to-back twice → two `rx_valid` pulses, each `rx_data` = 0x1F.
- `rstn` asserted during bit 4 → outputs 0 immediately; next frame 0xC3 is received correctly.
